// File: rtl/serial_link_pkg.sv
// Shared definitions for the sen/sd serial link: frame geometry, receiver
// FSM states and the error-cause encoding used by both link endpoints.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_PARITY,
    ERR_RANGE,
    ERR_SHORT,
    ERR_LONG
  } err_cause_t;

  function automatic int frame_w(input int addr_w, input int data_w, input int parity_en);
    return addr_w + data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/frame_deser.sv
// Shift register and bit counter for one sen/sd frame; flags complete,
// short and overlong frames with single-cycle pulses.
module frame_deser #(
  parameter int FRAME_W = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sen,
  input  logic               sd,
  output logic               last,
  output logic               frame_vld,
  output logic [FRAME_W-1:0] frame,
  output logic               short_err,
  output logic               long_err
);

  localparam int CW = $clog2(FRAME_W + 2);

  logic [CW-1:0]      count;
  logic [FRAME_W-1:0] shreg;

  assign last = !sen && (count == CW'(FRAME_W - 1));

  // Count parks at FRAME_W+1 after the first extra bit so a long frame flags once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count     <= '0;
      frame_vld <= 1'b0;
      short_err <= 1'b0;
      long_err  <= 1'b0;
    end else begin
      frame_vld <= 1'b0;
      short_err <= 1'b0;
      long_err  <= 1'b0;
      if (sen) begin
        count     <= '0;
        short_err <= (count != '0) && (count < CW'(FRAME_W));
      end else if (count < CW'(FRAME_W)) begin
        count     <= count + 1'b1;
        frame_vld <= last;
      end else if (count == CW'(FRAME_W)) begin
        count    <= count + 1'b1;
        long_err <= 1'b1;
      end
    end
  end

  // The completed frame is held separately so the next frame can shift in.
  always_ff @(posedge clk) begin
    if (!sen && (count < CW'(FRAME_W))) begin
      shreg <= {shreg[FRAME_W-2:0], sd};
    end
    if (last) begin
      frame <= {shreg[FRAME_W-2:0], sd};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial address+data frame receiver: validates parity/range/length and
// writes good frames to a single-port RAM port, counting good and bad frames.
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 18,
  parameter int DEPTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int NUM_FRAMES = 8,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB_RW,
  output logic [ADDR_W-1:0] RB_A,
  output logic [DATA_W-1:0] RB_D,
  output logic              done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W, PARITY_EN);

  logic               last;
  logic               frame_vld;
  logic               short_err;
  logic               long_err;
  logic [FRAME_W-1:0] frame;
  logic [ADDR_W-1:0]  f_addr;
  logic [DATA_W-1:0]  f_data;
  logic               pass;
  state_t             state;
  state_t             state_next;
  err_cause_t         cause;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign f_addr = frame[FRAME_W-1 -: ADDR_W];
  assign f_data = frame[FRAME_W-1-ADDR_W -: DATA_W];
  assign done   = (state == DONE);

  frame_deser #(
    .FRAME_W(FRAME_W)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .sen      (sen),
    .sd       (sd),
    .last     (last),
    .frame_vld(frame_vld),
    .frame    (frame),
    .short_err(short_err),
    .long_err (long_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cause      = ERR_NONE;
    pass       = 1'b0;
    case (state)
      IDLE:    if (!sen) state_next = SHIFT;
      SHIFT:   if (last) state_next = CHECK;
               else if (sen) state_next = IDLE;
      CHECK:   state_next = IDLE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (good_cnt >= CNT_W'(NUM_FRAMES)) state_next = DONE;

    // Completed frames are still judged in DONE so frame_err keeps reporting.
    if (short_err) begin
      cause = ERR_SHORT;
    end else if (long_err) begin
      cause = ERR_LONG;
    end else if (frame_vld) begin
      if ((PARITY_EN != 0) && (^frame)) cause = ERR_PARITY;
      else if (32'(f_addr) >= 32'(DEPTH)) cause = ERR_RANGE;
      else pass = 1'b1;
    end
  end

  // RAM port and counters; writes and counting stop once DONE is reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RB_RW     <= 1'b1;
      RB_A      <= '0;
      RB_D      <= '0;
      frame_err <= 1'b0;
      good_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      RB_RW     <= 1'b1;
      frame_err <= 1'b0;
      if (pass && (state != DONE)) begin
        RB_RW    <= 1'b0;
        RB_A     <= f_addr;
        RB_D     <= f_data;
        good_cnt <= sat_inc(good_cnt);
      end
      if (cause != ERR_NONE) begin
        frame_err <= 1'b1;
        if (state != DONE) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule
